mpu_elementwise_seq: RTL

Sequential, parametrised successor to the combinational matrix-opposite operator in the MPU.
- Applies a per-element unary operation to an N×N signed matrix: negate, or multiply by a signed scalar.
- Processes LANES elements per clock and reports progress through a start/busy/done handshake.
- Adds overflow detection and a sticky overflow flag.
- Sits beside the other MPU arithmetic operators and is driven by the MPU control sequencer.

---
 rtl/mpu_elementwise_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mpu_elementwise_seq.sv
// Sequential element-wise unary operator (negate or scale by a signed scalar) over an N x N matrix,
// LANES elements per beat. Define MPU_SATURATE_EN to clamp out-of-range results instead of wrapping.
module mpu_elementwise_seq #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 5,
  parameter int unsigned LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [W-1:0]       scalar,
  input  logic [W*N*N-1:0]   matrix_a,
  output logic               busy,
  output logic               done,
  output logic [W*N*N-1:0]   result,
  output logic               overflow
);

  localparam int unsigned NE = N * N;
  localparam int unsigned IW = $clog2(NE + LANES + 1);

  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W*NE-1:0]   a_q, a_d;
  logic [W*NE-1:0]   res_q, res_d;
  logic              mode_q, mode_d;
  logic [W-1:0]      sc_q, sc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;

  // Returns {overflow, stored value}; the exact value is held at 2W bits so both ops share the range check.
  function automatic logic [W:0] elem_op(input logic [W-1:0] a, input logic m, input logic [W-1:0] s);
    logic signed [W:0]     neg;
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] se;
    logic signed [2*W-1:0] exact;
    logic                  o;
    logic [W-1:0]          v;
    neg = -$signed({a[W-1], a});
    ae  = {{W{a[W-1]}}, a};
    se  = {{W{s[W-1]}}, s};
    if (m) begin
      exact = ae * se;
    end else begin
      exact = {{(W-1){neg[W]}}, neg};
    end
    o = (exact > MAXV) || (exact < MINV);
`ifdef MPU_SATURATE_EN
    if (exact > MAXV) begin
      v = MAXV[W-1:0];
    end else if (exact < MINV) begin
      v = MINV[W-1:0];
    end else begin
      v = exact[W-1:0];
    end
`else
    v = exact[W-1:0];
`endif
    return {o, v};
  endfunction

  always_comb begin
    int unsigned e;
    logic [W:0]  r;
    e       = 0;
    r       = '0;
    state_d = state_q;
    a_d     = a_q;
    res_d   = res_q;
    mode_d  = mode_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = matrix_a;
          mode_d  = mode;
          sc_d    = scalar;
          res_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          e = 32'(idx_q) + l;
          if (e < NE) begin
            r = elem_op(a_q[e*W +: W], mode_q, sc_q);
            res_d[e*W +: W] = r[W-1:0];
            if (r[W]) begin
              ovf_d = 1'b1;
            end
          end
        end
        idx_d = idx_q + IW'(LANES);
        if (32'(idx_q) + LANES >= NE) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      sc_q    <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign overflow = ovf_q;

endmodule
